dispatch_multi: RTL and testbench

Parametrised dispatch stage between rename and the functional units. It accepts one renamed instruction per cycle and steers it into one of `NUM_FU` reservation-station banks. It tracks physical-register readiness in a scoreboard and wakes waiting operands from `NUM_WB` writeback ports. Each cycle it issues at most one ready entry per FU, and on a branch mispredict it squashes younger work.

---
 rtl/dispatch_multi_pkg.sv | 40 ++++
 rtl/dispatch_multi_rs_bank.sv | 118 +++++++++++
 rtl/dispatch_multi.sv | 101 ++++++++++
 tb/tb_dispatch_multi.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_multi_pkg.sv
// Shared types, FU encodings and ROB age helpers for the dispatch_multi stage.
// Struct field widths are fixed here, so the top-level width parameters must keep these defaults.
package dispatch_multi_pkg;

    localparam int PREG_BITS = 7;
    localparam int ROB_BITS  = 5;
    localparam int FU_W      = 3;

    localparam logic [FU_W-1:0] FU_ALU = 3'd1;
    localparam logic [FU_W-1:0] FU_BR  = 3'd2;
    localparam logic [FU_W-1:0] FU_MEM = 3'd3;

    typedef struct packed {
        logic [FU_W-1:0]      fu;
        logic [PREG_BITS-1:0] ps1;
        logic [PREG_BITS-1:0] ps2;
        logic [PREG_BITS-1:0] pd_new;
        logic                 rd_valid;
    } rename_data;

    typedef struct packed {
        logic [PREG_BITS-1:0] ps1;
        logic [PREG_BITS-1:0] ps2;
        logic [PREG_BITS-1:0] pd_new;
        logic [ROB_BITS-1:0]  rob_index;
    } rs_data;

    function automatic logic [ROB_BITS-1:0] rob_age(input logic [ROB_BITS-1:0] tag,
                                                    input logic [ROB_BITS-1:0] head);
        return tag - head;
    endfunction

    // True when tag a was allocated after tag b, both measured from the ROB head.
    function automatic logic rob_younger(input logic [ROB_BITS-1:0] a,
                                         input logic [ROB_BITS-1:0] b,
                                         input logic [ROB_BITS-1:0] head);
        return rob_age(a, head) > rob_age(b, head);
    endfunction

endpackage

// File: rtl/dispatch_multi_rs_bank.sv
// One reservation-station bank: storage, operand wakeup, select, mispredict flush and occupancy.
// DISPATCH_AGE_ORDER_EN selects oldest-ROB-first; otherwise the lowest ready index issues.
module rs_bank
    import dispatch_multi_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int NUM_WB   = 3,
    parameter int PREG_W   = PREG_BITS,
    parameter int ROB_W    = ROB_BITS,
    localparam int CNT_W   = $clog2(RS_DEPTH + 1),
    localparam int IDX_W   = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc,
    input  rs_data                       alloc_data,
    input  logic                         alloc_rdy1,
    input  logic                         alloc_rdy2,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB-1:0][PREG_W-1:0] wb_preg,
    input  logic                         fu_ready,
    input  logic [ROB_W-1:0]             rob_head,
    input  logic                         mispredict,
    input  logic [ROB_W-1:0]             mispredict_tag,
    output logic                         full,
    output logic                         issue_valid,
    output rs_data                       issue_data,
    output logic [CNT_W-1:0]             count
);

    rs_data              entry_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] valid_q, rdy1_q, rdy2_q;
    logic [RS_DEPTH-1:0] wake1, wake2, kill, cand, valid_nxt;
    logic [IDX_W-1:0]    free_idx, sel_idx;
    logic                sel_found, do_issue;
    logic [CNT_W-1:0]    count_nxt;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wake1 = rdy1_q;
        wake2 = rdy2_q;
        kill  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_valid[w] && wb_preg[w] == entry_q[i].ps1) wake1[i] = 1'b1;
                if (wb_valid[w] && wb_preg[w] == entry_q[i].ps2) wake2[i] = 1'b1;
            end
            kill[i] = mispredict && valid_q[i]
                      && rob_younger(entry_q[i].rob_index, mispredict_tag, rob_head);
        end
        // Flushed entries are excluded so an older ready entry can still issue this cycle.
        cand = valid_q & rdy1_q & rdy2_q & ~kill;
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef DISPATCH_AGE_ORDER_EN
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cand[i] && (!sel_found
                || rob_younger(entry_q[sel_idx].rob_index, entry_q[i].rob_index, rob_head))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
`else
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        full     = &valid_q;
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
        do_issue  = sel_found && fu_ready;
        valid_nxt = valid_q & ~kill;
        if (do_issue) valid_nxt[sel_idx] = 1'b0;
        if (alloc && !full) valid_nxt[free_idx] = 1'b1;
        count_nxt = '0;
        for (int i = 0; i < RS_DEPTH; i++) count_nxt = count_nxt + CNT_W'(valid_nxt[i]);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            issue_valid <= 1'b0;
            issue_data  <= '0;
            count       <= '0;
        end else begin
            valid_q <= valid_nxt;
            rdy1_q  <= wake1;
            rdy2_q  <= wake2;
            if (alloc && !full) begin
                rdy1_q[free_idx] <= alloc_rdy1;
                rdy2_q[free_idx] <= alloc_rdy2;
            end
            issue_valid <= do_issue;
            if (do_issue) issue_data <= entry_q[sel_idx];
            count <= count_nxt;
        end
    end

    // NOTE: payload storage has no reset; valid_q alone decides whether an entry means anything.
    always_ff @(posedge clk) begin
        if (alloc && !full) entry_q[free_idx] <= alloc_data;
    end

endmodule

// File: rtl/dispatch_multi.sv
// Dispatch stage: steers renamed instructions into NUM_FU reservation banks and owns the
// physical-register scoreboard. Issue order per bank is set by DISPATCH_AGE_ORDER_EN.
module dispatch_multi
    import dispatch_multi_pkg::*;
#(
    parameter int NUM_FU   = 3,
    parameter int RS_DEPTH = 8,
    parameter int NUM_WB   = 3,
    parameter int PREG_W   = PREG_BITS,
    parameter int ROB_W    = ROB_BITS,
    localparam int CNT_W   = $clog2(RS_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  rename_data                    data_in,
    output logic                          ready_in,
    input  logic                          rob_full,
    input  logic [ROB_W-1:0]              rob_index_in,
    input  logic [ROB_W-1:0]              rob_head,
    input  logic                          mispredict,
    input  logic [ROB_W-1:0]              mispredict_tag,
    input  logic [NUM_WB-1:0]             wb_valid,
    input  logic [NUM_WB-1:0][PREG_W-1:0] wb_preg,
    input  logic [NUM_FU-1:0]             fu_ready,
    output logic [NUM_FU-1:0]             issue_valid,
    output rs_data [NUM_FU-1:0]           issue_data,
    output logic [NUM_FU-1:0][CNT_W-1:0]  rs_count
);

    logic [2**PREG_W-1:0] sb_ready;
    logic [NUM_FU-1:0]    bank_full, alloc;
    logic                 fu_ok, tgt_full, accept, src1_rdy, src2_rdy;
    rs_data               alloc_data;

    always_comb begin
        fu_ok    = 1'b0;
        tgt_full = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (data_in.fu == FU_W'(k + 1)) begin
                fu_ok    = 1'b1;
                tgt_full = bank_full[k];
            end
        end
        ready_in = !rob_full && !mispredict && fu_ok && !tgt_full;
        accept   = valid_in && ready_in;
        alloc    = '0;
        for (int k = 0; k < NUM_FU; k++) alloc[k] = accept && (data_in.fu == FU_W'(k + 1));

        src1_rdy = (data_in.ps1 == '0) || sb_ready[data_in.ps1];
        src2_rdy = (data_in.ps2 == '0) || sb_ready[data_in.ps2];
        for (int w = 0; w < NUM_WB; w++) begin
            if (wb_valid[w] && wb_preg[w] == data_in.ps1) src1_rdy = 1'b1;
            if (wb_valid[w] && wb_preg[w] == data_in.ps2) src2_rdy = 1'b1;
        end
        alloc_data.ps1       = data_in.ps1;
        alloc_data.ps2       = data_in.ps2;
        alloc_data.pd_new    = data_in.pd_new;
        alloc_data.rob_index = rob_index_in;
    end

    // The destination clear comes last so it overrides a same-cycle writeback to that preg.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_ready <= '1;
        end else begin
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_valid[w]) sb_ready[wb_preg[w]] <= 1'b1;
            end
            if (accept && data_in.rd_valid && data_in.pd_new != '0)
                sb_ready[data_in.pd_new] <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_bank
        rs_bank #(
            .RS_DEPTH (RS_DEPTH),
            .NUM_WB   (NUM_WB),
            .PREG_W   (PREG_W),
            .ROB_W    (ROB_W)
        ) u_bank (
            .clk            (clk),
            .reset          (reset),
            .alloc          (alloc[k]),
            .alloc_data     (alloc_data),
            .alloc_rdy1     (src1_rdy),
            .alloc_rdy2     (src2_rdy),
            .wb_valid       (wb_valid),
            .wb_preg        (wb_preg),
            .fu_ready       (fu_ready[k]),
            .rob_head       (rob_head),
            .mispredict     (mispredict),
            .mispredict_tag (mispredict_tag),
            .full           (bank_full[k]),
            .issue_valid    (issue_valid[k]),
            .issue_data     (issue_data[k]),
            .count          (rs_count[k])
        );
    end

endmodule

// File: tb/tb_dispatch_multi.sv
// Directed bench for dispatch_multi: a ready_in vector table plus hand-written multi-cycle sequences.
`timescale 1ns/100ps
module tb_dispatch_multi;
    import dispatch_multi_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                valid_in;
    rename_data          data_in;
    logic                ready_in;
    logic                rob_full;
    logic [4:0]          rob_index_in;
    logic [4:0]          rob_head;
    logic                mispredict;
    logic [4:0]          mispredict_tag;
    logic [2:0]          wb_valid;
    logic [2:0][6:0]     wb_preg;
    logic [2:0]          fu_ready;
    logic [2:0]          issue_valid;
    rs_data [2:0]        issue_data;
    logic [2:0][3:0]     rs_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] fu;
        logic       rob_full;
        logic       mispredict;
        logic       exp_ready;
        string      name;
    } rdy_vec_t;

    rdy_vec_t vecs [8];
    logic [4:0] exp_first, exp_second;

    dispatch_multi dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .ready_in       (ready_in),
        .rob_full       (rob_full),
        .rob_index_in   (rob_index_in),
        .rob_head       (rob_head),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .wb_valid       (wb_valid),
        .wb_preg        (wb_preg),
        .fu_ready       (fu_ready),
        .issue_valid    (issue_valid),
        .issue_data     (issue_data),
        .rs_count       (rs_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fu, input logic [6:0] ps1, input logic [6:0] ps2,
                         input logic [6:0] pd, input logic rdv, input logic [4:0] rob);
        valid_in         = 1'b1;
        data_in.fu       = fu;
        data_in.ps1      = ps1;
        data_in.ps2      = ps2;
        data_in.pd_new   = pd;
        data_in.rd_valid = rdv;
        rob_index_in     = rob;
    endtask

    task automatic idle();
        valid_in   = 1'b0;
        wb_valid   = '0;
        mispredict = 1'b0;
        rob_full   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd1, 1'b0, 1'b0, 1'b1, "rdy_alu_free"};
        vecs[1] = '{3'd2, 1'b0, 1'b0, 1'b1, "rdy_br_free"};
        vecs[2] = '{3'd3, 1'b0, 1'b0, 1'b0, "rdy_mem_full"};
        vecs[3] = '{3'd0, 1'b0, 1'b0, 1'b0, "rdy_fu_zero"};
        vecs[4] = '{3'd4, 1'b0, 1'b0, 1'b0, "rdy_fu_four"};
        vecs[5] = '{3'd7, 1'b0, 1'b0, 1'b0, "rdy_fu_seven"};
        vecs[6] = '{3'd1, 1'b1, 1'b0, 1'b0, "rdy_rob_full"};
        vecs[7] = '{3'd1, 1'b0, 1'b1, 1'b0, "rdy_mispredict"};

        reset = 1'b1;
        idle();
        data_in        = '0;
        rob_index_in   = '0;
        rob_head       = '0;
        mispredict_tag = '0;
        wb_preg        = '0;
        fu_ready       = '0;
        tick();
        tick();
        reset = 1'b0;
        data_in.fu = FU_ALU;
        #1;
        check("reset_issue_valid", 32'(issue_valid), 0);
        check("reset_rs_count", 32'(rs_count), 0);
        check("reset_ready_in", 32'(ready_in), 1);

        // Basic ALU dispatch and issue two edges after presentation.
        drive(FU_ALU, 7'd5, 7'd0, 7'd40, 1'b1, 5'd3);
        fu_ready = 3'b001;
        tick();
        idle();
        check("alu_not_yet", 32'(issue_valid), 0);
        check("alu_count1", 32'(rs_count[0]), 1);
        tick();
        check("alu_issue", 32'(issue_valid), 32'b001);
        check("alu_pd", 32'(issue_data[0].pd_new), 40);
        check("alu_rob", 32'(issue_data[0].rob_index), 3);
        check("alu_count0", 32'(rs_count[0]), 0);

        // Consumer of preg 40 waits for its writeback.
        drive(FU_ALU, 7'd40, 7'd0, 7'd45, 1'b1, 5'd4);
        tick();
        idle();
        tick();
        tick();
        check("busy40_wait", 32'(issue_valid), 0);
        check("busy40_count", 32'(rs_count[0]), 1);
        wb_valid   = 3'b001;
        wb_preg[0] = 7'd40;
        tick();
        wb_valid = '0;
        check("wake40_edge", 32'(issue_valid), 0);
        tick();
        check("wake40_issue", 32'(issue_valid), 32'b001);
        check("wake40_rob", 32'(issue_data[0].rob_index), 4);

        // Writeback bypass at dispatch.
        drive(FU_ALU, 7'd0, 7'd0, 7'd41, 1'b1, 5'd5);
        tick();
        idle();
        tick();
        drive(FU_ALU, 7'd41, 7'd0, 7'd46, 1'b0, 5'd6);
        wb_valid   = 3'b010;
        wb_preg[1] = 7'd41;
        tick();
        idle();
        tick();
        check("bypass_issue", 32'(issue_valid), 32'b001);
        check("bypass_rob", 32'(issue_data[0].rob_index), 6);

        // Allocation clear beats a same-cycle writeback on the same preg.
        drive(FU_ALU, 7'd0, 7'd0, 7'd42, 1'b1, 5'd7);
        wb_valid   = 3'b001;
        wb_preg[0] = 7'd42;
        tick();
        idle();
        drive(FU_ALU, 7'd42, 7'd0, 7'd0, 1'b0, 5'd8);
        tick();
        idle();
        tick();
        tick();
        check("clear_wins_wait", 32'(issue_valid[0]), 0);
        check("clear_wins_count", 32'(rs_count[0]), 1);
        wb_valid   = 3'b100;
        wb_preg[2] = 7'd42;
        tick();
        wb_valid = '0;
        tick();
        check("clear_wins_issue", 32'(issue_valid), 32'b001);
        check("clear_wins_rob", 32'(issue_data[0].rob_index), 8);
        fu_ready = '0;

        // Invalid FU codes are never accepted.
        drive(3'd0, 7'd0, 7'd0, 7'd50, 1'b1, 5'd9);
        #1;
        check("fu0_ready", 32'(ready_in), 0);
        tick();
        drive(3'd4, 7'd0, 7'd0, 7'd51, 1'b1, 5'd9);
        #1;
        check("fu4_ready", 32'(ready_in), 0);
        tick();
        idle();
        check("fu_bad_count", 32'(rs_count), 0);
        check("fu_bad_issue", 32'(issue_valid), 0);

        // Fill the MEM bank while its FU is blocked.
        for (int i = 0; i < 8; i++) begin
            drive(FU_MEM, 7'd0, 7'd0, 7'd0, 1'b0, 5'(i));
            tick();
        end
        idle();
        check("mem_full_count", 32'(rs_count[2]), 8);
        for (int i = 0; i < 8; i++) begin
            data_in.fu = vecs[i].fu;
            rob_full   = vecs[i].rob_full;
            mispredict = vecs[i].mispredict;
            #1;
            check(vecs[i].name, 32'(ready_in), 32'(vecs[i].exp_ready));
        end
        idle();
        drive(FU_MEM, 7'd0, 7'd0, 7'd0, 1'b0, 5'd20);
        fu_ready = 3'b100;
        #1;
        check("full_issue_ready", 32'(ready_in), 0);
        tick();
        fu_ready = '0;
        drive(FU_MEM, 7'd0, 7'd0, 7'd0, 1'b0, 5'd8);
        #1;
        check("mem_issue", 32'(issue_valid), 32'b100);
        check("mem_issue_rob", 32'(issue_data[2].rob_index), 0);
        check("mem_dec_count", 32'(rs_count[2]), 7);
        check("mem_resume_ready", 32'(ready_in), 1);
        tick();
        idle();
        check("mem_resume_count", 32'(rs_count[2]), 8);
        fu_ready = 3'b100;
        for (int i = 0; i < 8; i++) tick();
        fu_ready = '0;
        check("mem_drained", 32'(rs_count[2]), 0);

        // Mispredict flush with a wrapped ROB head.
        rob_head = 5'd30;
        drive(FU_ALU, 7'd0, 7'd0, 7'd0, 1'b0, 5'd31);
        tick();
        drive(FU_ALU, 7'd0, 7'd0, 7'd0, 1'b0, 5'd1);
        tick();
        drive(FU_ALU, 7'd0, 7'd0, 7'd0, 1'b0, 5'd4);
        tick();
        idle();
        check("flush_pre_count", 32'(rs_count[0]), 3);
        drive(FU_ALU, 7'd0, 7'd0, 7'd0, 1'b0, 5'd9);
        mispredict     = 1'b1;
        mispredict_tag = 5'd1;
        fu_ready       = 3'b001;
        #1;
        check("flush_ready_in", 32'(ready_in), 0);
        tick();
        idle();
        fu_ready = '0;
        check("flush_older_issue", 32'(issue_valid), 32'b001);
        check("flush_older_rob", 32'(issue_data[0].rob_index), 31);
        check("flush_count", 32'(rs_count[0]), 1);
        fu_ready = 3'b001;
        tick();
        fu_ready = '0;
        check("flush_kept_issue", 32'(issue_valid), 32'b001);
        check("flush_kept_rob", 32'(issue_data[0].rob_index), 1);
        tick();
        check("flush_empty", 32'(rs_count[0]), 0);
        check("flush_no_issue", 32'(issue_valid), 0);

        // Select order between two ready entries.
        rob_head = 5'd0;
`ifdef DISPATCH_AGE_ORDER_EN
        exp_first  = 5'd2;
        exp_second = 5'd6;
`else
        exp_first  = 5'd6;
        exp_second = 5'd2;
`endif
        drive(FU_ALU, 7'd0, 7'd0, 7'd0, 1'b0, 5'd6);
        tick();
        drive(FU_ALU, 7'd0, 7'd0, 7'd0, 1'b0, 5'd2);
        tick();
        idle();
        fu_ready = 3'b001;
        tick();
        check("order_first", 32'(issue_data[0].rob_index), 32'(exp_first));
        tick();
        check("order_second", 32'(issue_data[0].rob_index), 32'(exp_second));
        check("order_second_valid", 32'(issue_valid), 32'b001);
        fu_ready = '0;
        tick();

        // Reset mid-operation discards the pending entry and issue.
        drive(FU_BR, 7'd0, 7'd0, 7'd0, 1'b0, 5'd10);
        tick();
        idle();
        check("midreset_pre", 32'(rs_count[1]), 1);
        reset    = 1'b1;
        fu_ready = 3'b010;
        tick();
        reset = 1'b0;
        check("midreset_issue", 32'(issue_valid), 0);
        check("midreset_count", 32'(rs_count[1]), 0);
        tick();
        fu_ready = '0;
        check("midreset_after", 32'(issue_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
